// File: rtl/par_to_ser_c.sv
// Byte serializer fed by the 2:1 byte mux: queues valid bytes in a small FIFO and
// shifts them out MSB-first, filling gaps with the IDLE_SYM comma so the line never stalls.
module par_to_ser_c #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM   = 8'hBC
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_W-1:0]                     data_in,
  input  logic                                  valid_in,
  output logic                                  data_out,
  output logic                                  frame_start,
  output logic                                  sym_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
  output logic                                  fifo_full,
  output logic                                  fifo_empty,
  output logic                                  overflow
);

  localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [COUNT_W-1:0] FULL_CNT  = COUNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } sym_state_e;

  sym_state_e         state_q,       state_d;
  logic [DATA_W-1:0]  shift_q,       shift_d;
  logic [CNT_W-1:0]   bit_cnt_q,     bit_cnt_d;
  logic               frame_start_q, frame_start_d;
  logic [PTR_W-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,      rd_ptr_d;
  logic [COUNT_W-1:0] count_q,       count_d;
  logic               full_q,        full_d;
  logic               empty_q,       empty_d;
  logic               overflow_q,    overflow_d;

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

  logic               boundary;
  logic               pop;
  logic               push;

  // State register: symbol type, shifter, bit counter and FIFO bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= LAST_BIT;
      frame_start_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_start_q <= frame_start_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Next-state: a pop at a boundary frees the slot a same-edge push may then use.
  always_comb begin
    state_d       = state_q;
    shift_d       = {shift_q[DATA_W-2:0], 1'b0};
    bit_cnt_d     = bit_cnt_q + CNT_W'(1);
    frame_start_d = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;

    boundary = (bit_cnt_q == LAST_BIT);
    pop      = boundary && !empty_q;
    push     = valid_in && (!full_q || pop);

    if (boundary) begin
      bit_cnt_d     = '0;
      frame_start_d = 1'b1;
      if (pop) begin
        state_d  = ST_DATA;
        shift_d  = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        state_d  = ST_IDLE;
        shift_d  = IDLE_SYM;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else if (valid_in) begin
      overflow_d = 1'b1;
    end

    count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  assign data_out    = shift_q[DATA_W-1];
  assign frame_start = frame_start_q;
  assign sym_valid   = (state_q == ST_DATA);
  assign fifo_count  = count_q;
  assign fifo_full   = full_q;
  assign fifo_empty  = empty_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_par_to_ser_c.sv
// Bench for par_to_ser_c: a cycle-level FIFO/serializer model queues the expected symbol
// at every boundary and a monitor reassembles serial symbols and checks them in order.
module tb_par_to_ser_c;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       frame_start;
  logic       sym_valid;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;

  par_to_ser_c #(
    .DATA_W    (8),
    .FIFO_DEPTH(4),
    .IDLE_SYM  (8'hBC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .frame_start(frame_start),
    .sym_valid  (sym_valid),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 7 means the coming edge is a symbol boundary.
  logic [7:0] mfifo[$];
  logic [8:0] exp_sym[$];
  int         mphase = 7;
  logic       mov    = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      mfifo.delete();
      exp_sym.delete();
      mphase = 7;
      mov    = 1'b0;
    end else begin
      bit bnd;
      bit pop;
      bit acc;
      int sz;
      sz  = mfifo.size();
      bnd = (mphase == 7);
      pop = bnd && (sz > 0);
      acc = valid_in && ((sz < 4) || pop);
      if (bnd) begin
        if (pop) exp_sym.push_back({1'b1, mfifo.pop_front()});
        else     exp_sym.push_back({1'b0, 8'hBC});
      end
      if (acc) mfifo.push_back(data_in);
      else if (valid_in) mov = 1'b1;
      mphase = bnd ? 0 : mphase + 1;
    end
  end

  // Monitor: rebuild each serial symbol and pop the scoreboard when it completes.
  int         mon_n     = -1;
  logic [7:0] mon_byte  = '0;
  logic       mon_sv    = 1'b0;
  int         mon_syms  = 0;
  int         mon_data  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_n = -1;
    end else begin
      if (mon_n == 8) begin
        vectors++;
        if (frame_start !== 1'b1) begin
          miscompares++;
          $display("FAIL frame_gap: frame_start=%0b required 1 after symbol end", frame_start);
        end
      end
      if (frame_start === 1'b1) begin
        if (mon_n >= 1 && mon_n <= 7) begin
          miscompares++;
          $display("FAIL frame_early: frame_start after %0d bits, required 8", mon_n);
        end
        mon_n    = 0;
        mon_byte = '0;
        mon_sv   = sym_valid;
      end else if (mon_n == 8) begin
        mon_n = -1;
      end
      if (mon_n >= 0 && mon_n < 8) begin
        mon_byte = {mon_byte[6:0], data_out};
        if (sym_valid !== mon_sv) begin
          miscompares++;
          vectors++;
          $display("FAIL sym_valid_hold: got %0b required %0b within symbol", sym_valid, mon_sv);
        end
        mon_n++;
        if (mon_n == 8) begin
          logic [8:0] e;
          vectors++;
          mon_syms++;
          if (mon_sv) mon_data++;
          if (exp_sym.size() == 0) begin
            miscompares++;
            $display("FAIL symbol: got sv=%0b byte=%02h, none expected", mon_sv, mon_byte);
          end else begin
            e = exp_sym.pop_front();
            if ({mon_sv, mon_byte} !== e) begin
              miscompares++;
              $display("FAIL symbol: got sv=%0b byte=%02h required sv=%0b byte=%02h",
                       mon_sv, mon_byte, e[8], e[7:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic cycle(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (mphase != p && n < 20) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    vectors++;
    if (mphase != p) begin
      miscompares++;
      $display("FAIL wait_phase: phase %0d required %0d", mphase, p);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    vectors += 7;
    if (data_out !== 1'b0)      begin miscompares++; $display("FAIL rst_data_out: got %0b required 0", data_out); end
    if (frame_start !== 1'b0)   begin miscompares++; $display("FAIL rst_frame_start: got %0b required 0", frame_start); end
    if (sym_valid !== 1'b0)     begin miscompares++; $display("FAIL rst_sym_valid: got %0b required 0", sym_valid); end
    if (fifo_count !== 3'd0)    begin miscompares++; $display("FAIL rst_count: got %0d required 0", fifo_count); end
    if (fifo_empty !== 1'b1)    begin miscompares++; $display("FAIL rst_empty: got %0b required 1", fifo_empty); end
    if (fifo_full !== 1'b0)     begin miscompares++; $display("FAIL rst_full: got %0b required 0", fifo_full); end
    if (overflow !== 1'b0)      begin miscompares++; $display("FAIL rst_overflow: got %0b required 0", overflow); end
    reset = 1'b1;
  endtask

  task automatic test_idle();
    int s0 = mon_syms;
    repeat (32) begin
      cycle(1'b0, 8'h00);
      vectors++;
      if (fifo_empty !== 1'b1 || sym_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_flags: empty=%0b sym_valid=%0b required 1/0", fifo_empty, sym_valid);
      end
    end
    #1;
    vectors++;
    if (mon_syms - s0 != 4) begin
      miscompares++;
      $display("FAIL idle_symbols: got %0d symbols required 4", mon_syms - s0);
    end
  endtask

  task automatic test_single();
    int d0 = mon_data;
    wait_phase(3);
    cycle(1'b1, 8'h11);
    vectors++;
    if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL single_count_push: got %0d required 1", fifo_count); end
    wait_phase(7);
    cycle(1'b0, 8'h00);
    vectors += 3;
    if (fifo_count !== 3'd0)  begin miscompares++; $display("FAIL single_count_pop: got %0d required 0", fifo_count); end
    if (sym_valid !== 1'b1)   begin miscompares++; $display("FAIL single_sym_valid: got %0b required 1", sym_valid); end
    if (frame_start !== 1'b1) begin miscompares++; $display("FAIL single_frame: got %0b required 1", frame_start); end
    repeat (24) cycle(1'b0, 8'h00);
    #1;
    vectors++;
    if (mon_data - d0 != 1) begin miscompares++; $display("FAIL single_data_syms: got %0d required 1", mon_data - d0); end
  endtask

  task automatic test_overflow();
    wait_phase(0);
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'hFE);
    cycle(1'b1, 8'hFD);
    cycle(1'b1, 8'hFC);
    vectors += 3;
    if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count_full: got %0d required 4", fifo_count); end
    if (fifo_full !== 1'b1)  begin miscompares++; $display("FAIL ovf_full: got %0b required 1", fifo_full); end
    if (overflow !== 1'b0)   begin miscompares++; $display("FAIL ovf_early: got %0b required 0", overflow); end
    cycle(1'b1, 8'hFB);
    vectors += 2;
    if (overflow !== 1'b1)   begin miscompares++; $display("FAIL ovf_set: got %0b required 1", overflow); end
    if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count_drop: got %0d required 4", fifo_count); end
    repeat (48) cycle(1'b0, 8'h00);
    vectors += 2;
    if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL ovf_drain: got empty=%0b required 1", fifo_empty); end
    if (overflow !== 1'b1)   begin miscompares++; $display("FAIL ovf_sticky: got %0b required 1", overflow); end
  endtask

  task automatic test_full_boundary();
    wait_phase(0);
    cycle(1'b1, 8'h21);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h23);
    cycle(1'b1, 8'h24);
    wait_phase(7);
    cycle(1'b1, 8'h12);
    vectors += 4;
    if (fifo_count !== 3'd4)  begin miscompares++; $display("FAIL fb_count: got %0d required 4", fifo_count); end
    if (fifo_full !== 1'b1)   begin miscompares++; $display("FAIL fb_full: got %0b required 1", fifo_full); end
    if (overflow !== 1'b1)    begin miscompares++; $display("FAIL fb_overflow: got %0b required 1", overflow); end
    if (sym_valid !== 1'b1)   begin miscompares++; $display("FAIL fb_sym_valid: got %0b required 1", sym_valid); end
    repeat (48) cycle(1'b0, 8'h00);
    vectors++;
    if (fifo_empty !== 1'b1)  begin miscompares++; $display("FAIL fb_drain: got empty=%0b required 1", fifo_empty); end
  endtask

  task automatic test_reset_mid();
    int d0;
    int s0;
    wait_phase(0);
    cycle(1'b1, 8'h13);
    cycle(1'b1, 8'h14);
    cycle(1'b1, 8'h15);
    wait_phase(7);
    cycle(1'b0, 8'h00);
    vectors += 2;
    if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL rm_count_pre: got %0d required 2", fifo_count); end
    if (sym_valid !== 1'b1)  begin miscompares++; $display("FAIL rm_sym_pre: got %0b required 1", sym_valid); end
    repeat (3) cycle(1'b0, 8'h00);
    #2 reset = 1'b0;
    #1;
    vectors += 6;
    if (data_out !== 1'b0)    begin miscompares++; $display("FAIL rm_data_out: got %0b required 0", data_out); end
    if (fifo_count !== 3'd0)  begin miscompares++; $display("FAIL rm_count: got %0d required 0", fifo_count); end
    if (overflow !== 1'b0)    begin miscompares++; $display("FAIL rm_overflow: got %0b required 0", overflow); end
    if (fifo_empty !== 1'b1)  begin miscompares++; $display("FAIL rm_empty: got %0b required 1", fifo_empty); end
    if (sym_valid !== 1'b0)   begin miscompares++; $display("FAIL rm_sym_valid: got %0b required 0", sym_valid); end
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL rm_frame: got %0b required 0", frame_start); end
    valid_in = 1'b1;
    data_in  = 8'hAA;
    repeat (2) @(negedge clk);
    valid_in = 1'b0;
    vectors++;
    if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rm_ignore_valid: got %0d required 0", fifo_count); end
    reset = 1'b1;
    d0 = mon_data;
    s0 = mon_syms;
    repeat (40) cycle(1'b0, 8'h00);
    #1;
    vectors += 2;
    if (mon_data != d0)     begin miscompares++; $display("FAIL rm_stale_data: got %0d data symbols required 0", mon_data - d0); end
    if (mon_syms - s0 != 5) begin miscompares++; $display("FAIL rm_restart: got %0d symbols required 5", mon_syms - s0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      logic v;
      v = ($urandom_range(0, 9) < ((i < 150) ? 1 : 6));
      cycle(v, 8'($urandom));
      vectors += 3;
      if (fifo_count !== 3'(mfifo.size())) begin
        miscompares++;
        $display("FAIL b2b_count: got %0d required %0d", fifo_count, mfifo.size());
      end
      if (overflow !== mov) begin
        miscompares++;
        $display("FAIL b2b_overflow: got %0b required %0b", overflow, mov);
      end
      if (fifo_full !== (mfifo.size() == 4) || fifo_empty !== (mfifo.size() == 0)) begin
        miscompares++;
        $display("FAIL b2b_flags: full=%0b empty=%0b with %0d entries", fifo_full, fifo_empty, mfifo.size());
      end
    end
    repeat (48) cycle(1'b0, 8'h00);
    #1;
    vectors++;
    if (mfifo.size() != 0 || exp_sym.size() > 1) begin
      miscompares++;
      $display("FAIL b2b_drain: model fifo %0d, pending symbols %0d required 0/<=1",
               mfifo.size(), exp_sym.size());
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_overflow();
    test_full_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
